ps2_host_tx: RTL

- PS/2 host-to-device transmitter: the opposite direction to the existing ps2k keyboard receiver.
- Sends one command byte to a PS/2 device, e.g. 0xF4 (enable mouse reporting) on ps2m, or 0xED plus an LED byte on ps2k.
- Drives the open-drain clock and data lines through low-enable outputs; the top level builds the tristate.
- Sits beside ps2k/ps2m in the system clock domain and is sequenced by core logic.

---
 rtl/ps2_host_tx.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues a request-to-send,
// shifts one byte plus odd parity and stop out on device clocks, then checks the ack.
module ps2_host_tx #(
  parameter int unsigned INHIBIT = 6000,
  parameter int unsigned REQHOLD = 64,
  parameter int unsigned TIMEOUT = 840000,
  parameter int unsigned FILT    = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2CkI,
  input  logic       ps2DqI,
  output logic       ps2CkOe,
  output logic       ps2DqOe,
  input  logic       strb,
  input  logic [7:0] data,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int unsigned MAX_IR  = (INHIBIT > REQHOLD) ? INHIBIT : REQHOLD;
  localparam int unsigned MAX_CNT = (MAX_IR > TIMEOUT) ? MAX_IR : TIMEOUT;
  localparam int unsigned CW      = $clog2(MAX_CNT + 1);
  localparam int unsigned FW      = $clog2(FILT + 1);
  localparam int unsigned NW      = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQ,
    S_SEND,
    S_ACK,
    S_FIN
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NW-1:0]   n_q, n_d;
  logic [7:0]      data_q, data_d;
  logic            par_q, par_d;
  logic            nack_q, nack_d;
  logic            seen_q, seen_d;
  logic            ck_oe_q, ck_oe_d;
  logic            dq_oe_q, dq_oe_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            error_q, error_d;

  logic            ck_m_q, ck_m_d;
  logic            ck_s_q, ck_s_d;
  logic            dq_m_q, dq_m_d;
  logic            dq_s_q, dq_s_d;
  logic            ck_filt_q, ck_filt_d;
  logic [FW-1:0]   fcnt_q, fcnt_d;
  logic            fall_c;

  // Synchronisers plus clock glitch filter: a new level must persist FILT samples.
  always_comb begin
    ck_m_d    = ps2CkI;
    ck_s_d    = ck_m_q;
    dq_m_d    = ps2DqI;
    dq_s_d    = dq_m_q;
    ck_filt_d = ck_filt_q;
    fcnt_d    = '0;
    if (ck_s_q != ck_filt_q) begin
      if (fcnt_q == FW'(FILT - 1)) begin
        ck_filt_d = ck_s_q;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
    fall_c = ck_filt_q & ~ck_filt_d;
  end

  // Transfer sequencer; cnt_q serves as inhibit, request and timeout counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    data_d  = data_q;
    par_d   = par_q;
    nack_d  = nack_q;
    seen_d  = seen_q;
    ck_oe_d = ck_oe_q;
    dq_oe_d = dq_oe_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    error_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (strb) begin
          data_d  = data;
          par_d   = ~^data;
          busy_d  = 1'b1;
          ck_oe_d = 1'b1;
          dq_oe_d = 1'b0;
          cnt_d   = '0;
          state_d = S_INHIBIT;
        end
      end

      S_INHIBIT: begin
        if (cnt_q == CW'(INHIBIT - 1)) begin
          cnt_d   = '0;
          dq_oe_d = 1'b1;
          state_d = S_REQ;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_REQ: begin
        if (cnt_q == CW'(REQHOLD - 1)) begin
          cnt_d   = '0;
          n_d     = '0;
          ck_oe_d = 1'b0;
          state_d = S_SEND;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_SEND, S_ACK: begin
        if (cnt_q == CW'(TIMEOUT - 1)) begin
          // Timeout overrides any clock edge arriving in the same cycle.
          ck_oe_d = 1'b0;
          dq_oe_d = 1'b0;
          error_d = 1'b1;
          busy_d  = 1'b0;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (state_q == S_SEND) begin
            if (fall_c) begin
              n_d = n_q + 1'b1;
              if (n_q < NW'(8)) begin
                dq_oe_d = ~data_q[n_q[2:0]];
              end else if (n_q == NW'(8)) begin
                dq_oe_d = ~par_q;
              end else begin
                dq_oe_d = 1'b0;
                seen_d  = 1'b0;
                state_d = S_ACK;
              end
            end
          end else if (!seen_q) begin
            if (fall_c) begin
              nack_d = dq_s_q;
              seen_d = 1'b1;
            end
          end else if (ck_filt_q && dq_s_q) begin
            done_d  = ~nack_q;
            error_d = nack_q;
            busy_d  = 1'b0;
            state_d = S_FIN;
          end
        end
      end

      S_FIN: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      n_q       <= '0;
      data_q    <= '0;
      par_q     <= 1'b0;
      nack_q    <= 1'b0;
      seen_q    <= 1'b0;
      ck_oe_q   <= 1'b0;
      dq_oe_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      ck_m_q    <= 1'b1;
      ck_s_q    <= 1'b1;
      dq_m_q    <= 1'b1;
      dq_s_q    <= 1'b1;
      ck_filt_q <= 1'b1;
      fcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      n_q       <= n_d;
      data_q    <= data_d;
      par_q     <= par_d;
      nack_q    <= nack_d;
      seen_q    <= seen_d;
      ck_oe_q   <= ck_oe_d;
      dq_oe_q   <= dq_oe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
      ck_m_q    <= ck_m_d;
      ck_s_q    <= ck_s_d;
      dq_m_q    <= dq_m_d;
      dq_s_q    <= dq_s_d;
      ck_filt_q <= ck_filt_d;
      fcnt_q    <= fcnt_d;
    end
  end

  assign ps2CkOe = ck_oe_q;
  assign ps2DqOe = dq_oe_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign error   = error_q;

endmodule
